// File: rtl/pc_unit.sv
// Program counter with conditional branch, register jump and an optional
// circular return-address stack (compiled in with `define PC_UNIT_RAS_EN).
module pc_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  OFFSET_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  RAS_DEPTH    = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    BUSYWAIT,
  input  logic [2:0]              BJCTRL,
  input  logic                    ZERO,
  input  logic                    SIGN,
  input  logic [OFFSET_WIDTH-1:0] OFFSET,
  input  logic [PC_WIDTH-1:0]     REGTARGET,
  output logic [PC_WIDTH-1:0]     PC,
  output logic [PC_WIDTH-1:0]     PC_PLUS4,
  output logic                    TAKEN,
  output logic                    RAS_ERR
);

  localparam logic [2:0] F_NORM = 3'b000;
  localparam logic [2:0] F_J    = 3'b001;
  localparam logic [2:0] F_BEQ  = 3'b010;
  localparam logic [2:0] F_BNE  = 3'b011;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_JR   = 3'b101;
  localparam logic [2:0] F_CALL = 3'b110;
  localparam logic [2:0] F_RET  = 3'b111;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] off_ext;
  logic                taken;

  // Word offset: sign-extend, then scale to bytes.
  assign off_ext  = {{(PC_WIDTH-OFFSET_WIDTH-2){OFFSET[OFFSET_WIDTH-1]}}, OFFSET, 2'b00};
  assign PC       = pc_q;
  assign PC_PLUS4 = pc_q + PC_WIDTH'(4);
  assign target   = PC_PLUS4 + off_ext;
  assign TAKEN    = taken;

`ifdef PC_UNIT_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr_q, ras_ptr_d, ras_top;
  logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;
  logic                ras_err_q, ras_err_d;
  logic                ras_empty, ras_full;
  logic                do_call, do_ret;

  // ras_ptr_q is the next free slot; the newest entry sits one below it.
  assign ras_top   = ras_ptr_q - PTR_W'(1);
  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
  assign RAS_ERR   = ras_err_q;
`else
  assign RAS_ERR   = 1'b0;
`endif

  always_comb begin
    taken   = 1'b0;
    next_pc = PC_PLUS4;
`ifdef PC_UNIT_RAS_EN
    do_call = 1'b0;
    do_ret  = 1'b0;
`endif
    case (BJCTRL)
      F_NORM: taken = 1'b0;
      F_J:    taken = 1'b1;
      F_BEQ:  taken = ZERO;
      F_BNE:  taken = ~ZERO;
      F_BLT:  taken = SIGN;
      F_JR:   taken = 1'b1;
      F_CALL: begin
        taken = 1'b1;
`ifdef PC_UNIT_RAS_EN
        do_call = 1'b1;
`endif
      end
      F_RET: begin
`ifdef PC_UNIT_RAS_EN
        do_ret = 1'b1;
        taken  = ~ras_empty;
`else
        taken  = 1'b0;
`endif
      end
      default: taken = 1'b0;
    endcase

    if (BJCTRL == F_JR)
      next_pc = REGTARGET;
`ifdef PC_UNIT_RAS_EN
    else if (BJCTRL == F_RET && taken)
      next_pc = ras_mem_q[ras_top];
`endif
    else if (taken)
      next_pc = target;
  end

  assign pc_d = BUSYWAIT ? pc_q : next_pc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

`ifdef PC_UNIT_RAS_EN
  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_err_d = ras_err_q;
    if (!BUSYWAIT) begin
      if (do_call) begin
        // When full, the slot at the pointer holds the oldest entry.
        ras_mem_d[ras_ptr_q] = PC_PLUS4;
        ras_ptr_d            = ras_ptr_q + PTR_W'(1);
        if (!ras_full) ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end else if (do_ret) begin
        if (ras_empty) begin
          ras_err_d = 1'b1;
        end else begin
          ras_ptr_d = ras_top;
          ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      ras_err_q <= 1'b0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      ras_err_q <= ras_err_d;
    end
  end

  // Entries are only reachable through the count, so storage needs no reset.
  always_ff @(posedge CLK) begin
    ras_mem_q <= ras_mem_d;
  end
`endif

endmodule
